// File: rtl/router_pkt_tx.sv
// Transmit end of the 1x3 router packet protocol: buffers a payload, then sends header/payload/parity.
// Optional build macro TX_PARITY_CORRUPT_EN adds i_corrupt_parity to send an inverted parity byte.
module router_pkt_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 6,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_addr,
    input  logic [LEN_W-1:0]  i_len,
`ifdef TX_PARITY_CORRUPT_EN
    input  logic              i_corrupt_parity,
`endif
    output logic              o_tx_ready,
    output logic              o_tx_reject,
    input  logic [DATA_W-1:0] i_pl_data,
    input  logic              i_pl_valid,
    output logic              o_pl_ready,
    input  logic              i_busy,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_pkt_valid,
    output logic              o_tx_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_HEADER, S_PAYLOAD, S_PARITY, S_DONE
    } state_t;

    state_t              r_state;
    logic [1:0]          r_addr;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_wr_ptr;
    logic [LEN_W-1:0]    r_rd_ptr;
    logic [DATA_W-1:0]   r_parity;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_pkt_valid;
    logic                r_tx_done;
    logic                r_tx_reject;
    logic [DATA_W-1:0]   r_buf [DEPTH];

    logic                w_accept;
    logic                w_wr_en;
    logic                w_last_wr;
    logic                w_last_rd;
    logic [LEN_W-1:0]    w_wr_next;
    logic [LEN_W-1:0]    w_rd_next;
    logic [DATA_W-1:0]   w_header;
    logic [DATA_W-1:0]   w_par_out;

    assign w_accept  = (r_state == S_IDLE) && i_start && (i_addr != 2'b11);
    assign w_wr_en   = (r_state == S_FILL) && i_pl_valid;
    assign w_wr_next = r_wr_ptr + 1'b1;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign w_last_wr = (r_wr_ptr == r_len - 1'b1);
    assign w_last_rd = (r_rd_ptr == r_len - 1'b1);
    assign w_header  = {r_len, r_addr};

`ifdef TX_PARITY_CORRUPT_EN
    logic r_corrupt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_corrupt <= 1'b0;
        end else if (w_accept) begin
            r_corrupt <= i_corrupt_parity;
        end
    end

    assign w_par_out = r_parity ^ {DATA_W{r_corrupt}};
`else
    assign w_par_out = r_parity;
`endif

    // Payload storage needs no reset; the pointers alone define its contents.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_buf[r_wr_ptr] <= i_pl_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_parity    <= '0;
            r_data_out  <= '0;
            r_pkt_valid <= 1'b0;
            r_tx_done   <= 1'b0;
            r_tx_reject <= 1'b0;
        end else begin
            r_tx_done   <= 1'b0;
            r_tx_reject <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && (i_addr == 2'b11)) begin
                        r_tx_reject <= 1'b1;
                    end else if (w_accept) begin
                        r_addr   <= i_addr;
                        r_len    <= i_len;
                        r_parity <= {i_len, i_addr};
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        if (i_len == '0) begin
                            r_state     <= S_HEADER;
                            r_data_out  <= {i_len, i_addr};
                            r_pkt_valid <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (i_pl_valid) begin
                        r_wr_ptr <= w_wr_next;
                        r_parity <= r_parity ^ i_pl_data;
                        if (w_last_wr) begin
                            r_state     <= S_HEADER;
                            r_data_out  <= w_header;
                            r_pkt_valid <= 1'b1;
                        end
                    end
                end
                S_HEADER: begin
                    if (!i_busy) begin
                        if (r_len == '0) begin
                            r_state     <= S_PARITY;
                            r_data_out  <= w_par_out;
                            r_pkt_valid <= 1'b0;
                        end else begin
                            r_state    <= S_PAYLOAD;
                            r_data_out <= r_buf[r_rd_ptr];
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (!i_busy) begin
                        if (w_last_rd) begin
                            r_state     <= S_PARITY;
                            r_data_out  <= w_par_out;
                            r_pkt_valid <= 1'b0;
                        end else begin
                            r_rd_ptr   <= w_rd_next;
                            r_data_out <= r_buf[w_rd_next];
                        end
                    end
                end
                S_PARITY: begin
                    if (!i_busy) begin
                        r_state    <= S_DONE;
                        r_data_out <= '0;
                        r_tx_done  <= 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_ready  = (r_state == S_IDLE);
    assign o_pl_ready  = (r_state == S_FILL);
    assign o_tx_reject = r_tx_reject;
    assign o_data_out  = r_data_out;
    assign o_pkt_valid = r_pkt_valid;
    assign o_tx_done   = r_tx_done;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: hand-computed header/payload/parity sequences, busy stalls,
// illegal address, long packet with upstream gaps, and mid-packet reset.
module tb_router_pkt_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] addr;
    logic [5:0] len;
    logic       tx_ready;
    logic       tx_reject;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_done;
`ifdef TX_PARITY_CORRUPT_EN
    logic       corrupt = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pay [63];
    logic [7:0] par;

    always #5 clk = ~clk;

    router_pkt_tx dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_addr      (addr),
        .i_len       (len),
`ifdef TX_PARITY_CORRUPT_EN
        .i_corrupt_parity (corrupt),
`endif
        .o_tx_ready  (tx_ready),
        .o_tx_reject (tx_reject),
        .i_pl_data   (pl_data),
        .i_pl_valid  (pl_valid),
        .o_pl_ready  (pl_ready),
        .i_busy      (busy),
        .o_data_out  (data_out),
        .o_pkt_valid (pkt_valid),
        .o_tx_done   (tx_done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        chk(tag, {7'd0, obs}, {7'd0, exp_v});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pkt(input logic [1:0] a, input logic [5:0] l);
        start = 1'b1;
        addr  = a;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b);
        chk1("pl_ready", pl_ready, 1'b1);
        pl_valid = 1'b1;
        pl_data  = b;
        tick();
        pl_valid = 1'b0;
    endtask

    // Check the byte on the link, then let it be consumed (busy low).
    task automatic exp_byte(input string tag, input logic [7:0] d, input logic pv);
        chk({tag, "_data"}, data_out, d);
        chk1({tag, "_pv"}, pkt_valid, pv);
        tick();
    endtask

    task automatic exp_done();
        chk1("tx_done", tx_done, 1'b1);
        chk("done_data", data_out, 8'h00);
        tick();
        chk1("done_clear", tx_done, 1'b0);
        chk1("back_idle", tx_ready, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; addr = '0; len = '0;
        pl_data = '0; pl_valid = 1'b0; busy = 1'b0;
        #12;
        chk1("rst_tx_ready", tx_ready, 1'b1);
        chk1("rst_pkt_valid", pkt_valid, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk1("rst_tx_done", tx_done, 1'b0);
        chk1("rst_tx_reject", tx_reject, 1'b0);
        chk1("rst_pl_ready", pl_ready, 1'b0);
        rst_n = 1'b1;
        tick();

        // Test 1: addr=1 len=3, header {3,1}=0D; parity 0D^A1^B2^C3 = DD
        start_pkt(2'd1, 6'd3);
        chk1("t1_tx_ready", tx_ready, 1'b0);
        feed(8'hA1); feed(8'hB2); feed(8'hC3);
        exp_byte("t1_hdr", 8'h0D, 1'b1);
        exp_byte("t1_p0", 8'hA1, 1'b1);
        exp_byte("t1_p1", 8'hB2, 1'b1);
        exp_byte("t1_p2", 8'hC3, 1'b1);
        exp_byte("t1_par", 8'hDD, 1'b0);
        exp_done();

        // Test 2: addr=0 len=0 goes straight to header
        start_pkt(2'd0, 6'd0);
        chk1("t2_pl_ready", pl_ready, 1'b0);
        exp_byte("t2_hdr", 8'h00, 1'b1);
        chk1("t2_pl_ready2", pl_ready, 1'b0);
        exp_byte("t2_par", 8'h00, 1'b0);
        exp_done();

        // Test 3: addr=2 len=2 with busy stalls, header {2,2}=0A, parity 0A^11^22=39
        start_pkt(2'd2, 6'd2);
        feed(8'h11); feed(8'h22);
        busy = 1'b1;
        tick();
        chk("t3_hdr_hold", data_out, 8'h0A);
        chk1("t3_hdr_hold_pv", pkt_valid, 1'b1);
        busy = 1'b0;
        tick();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_p0_hold", data_out, 8'h11);
            chk1("t3_p0_hold_pv", pkt_valid, 1'b1);
            tick();
        end
        busy = 1'b0;
        exp_byte("t3_p0", 8'h11, 1'b1);
        exp_byte("t3_p1", 8'h22, 1'b1);
        exp_byte("t3_par", 8'h39, 1'b0);
        exp_done();

        // Test 4: illegal address
        start = 1'b1; addr = 2'd3; len = 6'd5;
        tick();
        start = 1'b0;
        chk1("t4_reject", tx_reject, 1'b1);
        chk1("t4_tx_ready", tx_ready, 1'b1);
        chk1("t4_pkt_valid", pkt_valid, 1'b0);
        chk1("t4_pl_ready", pl_ready, 1'b0);
        tick();
        chk1("t4_reject_clr", tx_reject, 1'b0);
        chk1("t4_pl_ready2", pl_ready, 1'b0);

        // Test 5: len=63 with upstream gaps; header {63,1}=FD; competing start is ignored
        par = 8'hFD;
        for (int i = 0; i < 63; i++) begin
            pay[i] = 8'($urandom);
            par    = par ^ pay[i];
        end
        start_pkt(2'd1, 6'd63);
        start = 1'b1; addr = 2'd2; len = 6'd5;
        for (int i = 0; i < 63; i++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                pl_data = 8'($urandom);
                tick();
            end
            pl_valid = 1'b1;
            pl_data  = pay[i];
            tick();
            pl_valid = 1'b0;
        end
        exp_byte("t5_hdr", 8'hFD, 1'b1);
        for (int i = 0; i < 63; i++) begin
            exp_byte("t5_pay", pay[i], 1'b1);
        end
        start = 1'b0;
        exp_byte("t5_par", par, 1'b0);
        exp_done();
        tick();
        chk1("t5_still_idle", tx_ready, 1'b1);

        // Test 6: reset mid-payload, then a fresh packet {1,2}=06, parity 06^5A=5C
        start_pkt(2'd1, 6'd3);
        feed(8'hA1); feed(8'hB2); feed(8'hC3);
        exp_byte("t6_hdr", 8'h0D, 1'b1);
        chk1("t6_in_payload", pkt_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("t6_rst_pv", pkt_valid, 1'b0);
        chk("t6_rst_data", data_out, 8'h00);
        chk1("t6_rst_ready", tx_ready, 1'b1);
        #2;
        rst_n = 1'b1;
        tick();
        chk1("t6_ready", tx_ready, 1'b1);
        start_pkt(2'd2, 6'd1);
        feed(8'h5A);
        exp_byte("t6_hdr2", 8'h06, 1'b1);
        exp_byte("t6_p0", 8'h5A, 1'b1);
        exp_byte("t6_par", 8'h5C, 1'b0);
        exp_done();

`ifdef TX_PARITY_CORRUPT_EN
        // Corrupted parity of test 1: ~DD = 22
        corrupt = 1'b1;
        start_pkt(2'd1, 6'd3);
        corrupt = 1'b0;
        feed(8'hA1); feed(8'hB2); feed(8'hC3);
        exp_byte("tc_hdr", 8'h0D, 1'b1);
        exp_byte("tc_p0", 8'hA1, 1'b1);
        exp_byte("tc_p1", 8'hB2, 1'b1);
        exp_byte("tc_p2", 8'hC3, 1'b1);
        exp_byte("tc_par", 8'h22, 1'b0);
        exp_done();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
